// File: rtl/i2c_write_engine_pkg.sv
// Word layout, opcode and FSM state type shared by the I2C register-write engine.
package i2c_write_engine_pkg;

  localparam int         OPC_MSB   = 31;
  localparam int         OPC_LSB   = 24;
  localparam int         UNITS_MSB = 15;
  localparam logic [7:0] OPC_DELAY = 8'hFF;
  localparam logic [1:0] LAST_BYTE = 2'd3;
  localparam logic [3:0] ACK_BIT   = 4'd8;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_BYTE,
    ST_STOP,
    ST_GAP,
    ST_DELAY
  } state_t;

  function automatic logic is_delay(input logic [31:0] word);
    return word[OPC_MSB:OPC_LSB] == OPC_DELAY;
  endfunction

  function automatic logic [15:0] delay_units(input logic [31:0] word);
    return word[UNITS_MSB:0];
  endfunction

endpackage

// File: rtl/i2c_quarter_tick.sv
// Quarter-bit timebase: one-cycle tick every CLK_DIV clocks while run is high.
module i2c_quarter_tick #(
  parameter int CLK_DIV = 125
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic tick
);

  localparam int            CW   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] count;

  // Restarting from zero whenever run drops keeps every transaction phase-aligned.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                        count <= '0;
    else if (!run || count == LAST) count <= '0;
    else                            count <= count + CW'(1);
  end

  assign tick = run && (count == LAST);

endmodule

// File: rtl/i2c_write_engine.sv
// Pops 32-bit command words and runs each as a 4-byte I2C write or a timed delay.
module i2c_write_engine
  import i2c_write_engine_pkg::*;
#(
  parameter int CLK_DIV     = 125,
  parameter int DELAY_TICKS = 27000,
  parameter int DATA_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_read,
  output logic                  scl_oe,
  output logic                  sda_oe,
  input  logic                  sda_i,
  output logic                  busy,
  output logic                  done,
  output logic                  nack_err
);

  localparam int            TW        = (DELAY_TICKS > 1) ? $clog2(DELAY_TICKS) : 1;
  localparam logic [TW-1:0] TICK_LAST = TW'(DELAY_TICKS - 1);

  state_t                state;
  logic [DATA_WIDTH-1:0] shift;
  logic [1:0]            quarter;
  logic [1:0]            byte_cnt;
  logic [3:0]            bit_cnt;
  logic                  ack_bit;
  logic [15:0]           units;
  logic [15:0]           unit_cnt;
  logic [TW-1:0]         tick_cnt;
  logic                  run;
  logic                  tick;

  assign run = (state != ST_IDLE) && (state != ST_DELAY);

  i2c_quarter_tick #(.CLK_DIV(CLK_DIV)) u_quarter_tick (
    .clk  (clk),
    .rst  (rst),
    .run  (run),
    .tick (tick)
  );

  // Quarter schedule per bit: q0 SDA set (SCL low), q1 SCL released, end of q2 sample, q3 SCL low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      shift     <= '0;
      quarter   <= 2'd0;
      byte_cnt  <= 2'd0;
      bit_cnt   <= 4'd0;
      ack_bit   <= 1'b0;
      units     <= 16'd0;
      unit_cnt  <= 16'd0;
      tick_cnt  <= '0;
      fifo_read <= 1'b0;
      scl_oe    <= 1'b0;
      sda_oe    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      nack_err  <= 1'b0;
    end else begin
      fifo_read <= 1'b0;
      done      <= 1'b0;
      if (tick) quarter <= quarter + 2'd1;
      case (state)
        ST_IDLE: begin
          quarter <= 2'd0;
          if (!fifo_empty) begin
            shift     <= fifo_dout;
            units     <= delay_units(fifo_dout);
            unit_cnt  <= 16'd0;
            tick_cnt  <= '0;
            byte_cnt  <= 2'd0;
            bit_cnt   <= 4'd0;
            fifo_read <= 1'b1;
            busy      <= 1'b1;
            state     <= is_delay(fifo_dout) ? ST_DELAY : ST_START;
          end
        end
        ST_START: begin
          if (tick) begin
            case (quarter)
              2'd1: sda_oe <= 1'b1;
              2'd2: scl_oe <= 1'b1;
              2'd3: begin
                sda_oe <= ~shift[DATA_WIDTH-1];
                state  <= ST_BYTE;
              end
              default: ;
            endcase
          end
        end
        ST_BYTE: begin
          if (tick) begin
            case (quarter)
              2'd0: scl_oe <= 1'b0;
              2'd2: begin
                scl_oe <= 1'b1;
                if (bit_cnt == ACK_BIT) begin
                  ack_bit <= sda_i;
                  if (sda_i) nack_err <= 1'b1;
                end
              end
              2'd3: begin
                if (bit_cnt != ACK_BIT) begin
                  bit_cnt <= bit_cnt + 4'd1;
                  shift   <= shift << 1;
                  sda_oe  <= (bit_cnt == ACK_BIT - 4'd1) ? 1'b0 : ~shift[DATA_WIDTH-2];
                end else if (ack_bit || byte_cnt == LAST_BYTE) begin
                  // SDA must be low under SCL low before it can rise for STOP.
                  sda_oe <= 1'b1;
                  state  <= ST_STOP;
                end else begin
                  byte_cnt <= byte_cnt + 2'd1;
                  bit_cnt  <= 4'd0;
                  sda_oe   <= ~shift[DATA_WIDTH-1];
                end
              end
              default: ;
            endcase
          end
        end
        ST_STOP: begin
          if (tick) begin
            case (quarter)
              2'd0: scl_oe <= 1'b0;
              2'd1: sda_oe <= 1'b0;
              2'd3: state  <= ST_GAP;
              default: ;
            endcase
          end
        end
        ST_GAP: begin
          if (tick && quarter == 2'd3) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        ST_DELAY: begin
          // Zero units still spends exactly one cycle here.
          if (units == 16'd0 || (unit_cnt == units - 16'd1 && tick_cnt == TICK_LAST)) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= ST_IDLE;
          end else if (tick_cnt == TICK_LAST) begin
            tick_cnt <= '0;
            unit_cnt <= unit_cnt + 16'd1;
          end else begin
            tick_cnt <= tick_cnt + TW'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_write_engine.sv
// Bench for i2c_write_engine: FIFO model, I2C bus monitor with ACKing slave, directed and random words.
module tb_i2c_write_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] fifo_dout;
  logic        fifo_empty;
  logic        fifo_read;
  logic        scl_oe;
  logic        sda_oe;
  logic        sda_line;
  logic        busy;
  logic        done;
  logic        nack_err;

  int errors = 0;
  int checks = 0;

  // FIFO model: main flow writes, pop process reads
  logic [31:0] fifo_mem [0:255];
  logic [7:0]  wr_ptr = 8'd0;
  logic [7:0]  rd_ptr = 8'd0;
  int          pop_cnt = 0;
  int          pop_vio = 0;
  logic        read_prev = 1'b0;
  int          done_cnt = 0;
  int          done_vio = 0;
  logic        done_prev = 1'b0;

  // Bus monitor and slave state
  logic        slave_pull = 1'b0;
  logic        scl_prev = 1'b1;
  logic        sda_prev = 1'b1;
  logic        scl_now;
  logic        sda_now;
  bit          mon_active = 1'b0;
  int          mon_bit_n = 0;
  int          mon_byte_idx = 0;
  logic [7:0]  shreg = 8'd0;
  logic [31:0] rx_bytes = 32'd0;
  int          rx_count = 0;
  int          nack_byte = -1;
  bit          have_stop = 1'b0;
  int          gap = 0;
  int          min_gap = 1000000;
  int          obs_cnt [0:63];
  logic [31:0] obs_bytes [0:63];
  int          obs_wr = 0;
  int          obs_rd = 0;

  int          exp_done = 0;
  logic        exp_nack = 1'b0;

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_dout  = fifo_mem[rd_ptr];
  assign sda_line   = !(sda_oe || slave_pull);

  i2c_write_engine #(.CLK_DIV(4), .DELAY_TICKS(10), .DATA_WIDTH(32)) dut (
    .clk        (clk),
    .rst        (rst),
    .fifo_dout  (fifo_dout),
    .fifo_empty (fifo_empty),
    .fifo_read  (fifo_read),
    .scl_oe     (scl_oe),
    .sda_oe     (sda_oe),
    .sda_i      (sda_line),
    .busy       (busy),
    .done       (done),
    .nack_err   (nack_err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (fifo_read) begin
      pop_cnt++;
      if (fifo_empty) pop_vio++;
      else rd_ptr = rd_ptr + 8'd1;
      if (read_prev) pop_vio++;
    end
    read_prev = fifo_read;
    if (done) begin
      done_cnt++;
      if (done_prev) done_vio++;
    end
    done_prev = done;
  end

  always @(negedge clk) begin
    scl_now = !scl_oe;
    sda_now = sda_line;
    if (rst) begin
      mon_active   = 1'b0;
      mon_bit_n    = 0;
      mon_byte_idx = 0;
      slave_pull   = 1'b0;
      have_stop    = 1'b0;
    end else if (scl_now && scl_prev && sda_prev && !sda_now) begin
      if (have_stop && gap < min_gap) min_gap = gap;
      mon_active   = 1'b1;
      mon_bit_n    = 0;
      mon_byte_idx = 0;
      rx_count     = 0;
      rx_bytes     = 32'd0;
    end else if (mon_active && scl_now && scl_prev && !sda_prev && sda_now) begin
      obs_cnt[obs_wr]   = rx_count;
      obs_bytes[obs_wr] = rx_bytes;
      obs_wr++;
      mon_active = 1'b0;
      slave_pull = 1'b0;
      have_stop  = 1'b1;
      gap        = 0;
    end else if (mon_active && scl_now && !scl_prev) begin
      if (mon_bit_n < 8) shreg = {shreg[6:0], sda_now};
      else if (mon_bit_n == 8) begin
        rx_bytes = {rx_bytes[23:0], shreg};
        rx_count++;
      end
      mon_bit_n++;
    end else if (mon_active && !scl_now && scl_prev) begin
      if (mon_bit_n == 8) slave_pull = (mon_byte_idx != nack_byte);
      else if (mon_bit_n == 9) begin
        slave_pull = 1'b0;
        mon_bit_n  = 0;
        mon_byte_idx++;
      end
    end
    if (!rst && !mon_active && have_stop && scl_now && sda_now) gap++;
    scl_prev = !scl_oe;
    sda_prev = sda_line;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] w, input bit sync);
    if (sync) begin
      @(negedge clk);
      #1;
    end
    fifo_mem[wr_ptr] = w;
    wr_ptr = wr_ptr + 8'd1;
  endtask

  task automatic waitDone(input int target);
    int n = 0;
    while (done_cnt < target && n < 5000) begin
      @(negedge clk);
      #1;
      n++;
    end
    checkOutput("done_count", 32'(done_cnt), 32'(target));
  endtask

  // Expected bus bytes: the whole word, or everything up to and including the NACKed byte
  task automatic checkTxn(input string tag, input logic [31:0] w, input int nack_idx);
    int          n;
    logic [31:0] expb;
    logic [31:0] oc;
    logic [31:0] ob;
    n    = (nack_idx >= 0 && nack_idx < 4) ? nack_idx + 1 : 4;
    expb = w >> (8 * (4 - n));
    if (obs_rd < obs_wr) begin
      oc = 32'(obs_cnt[obs_rd]);
      ob = obs_bytes[obs_rd];
      obs_rd++;
    end else begin
      oc = 32'd0;
      ob = 32'd0;
    end
    checkOutput({tag, "_nbytes"}, oc, 32'(n));
    checkOutput({tag, "_bytes"}, ob, expb);
  endtask

  task automatic runWord(input string tag, input logic [31:0] w, input int nack_idx);
    nack_byte = nack_idx;
    applyStimulus(w, 1'b1);
    exp_done++;
    if (nack_idx >= 0 && nack_idx < 4) exp_nack = 1'b1;
    waitDone(exp_done);
    checkTxn(tag, w, nack_idx);
    checkOutput({tag, "_nack_err"}, 32'(nack_err), 32'(exp_nack));
  endtask

  task automatic runDelay(input logic [15:0] units);
    int busy_cycles = 0;
    int line_act = 0;
    int n = 0;
    applyStimulus({8'hFF, 8'h00, units}, 1'b1);
    exp_done++;
    while (!busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    while (busy && n < 2000) begin
      busy_cycles++;
      if (scl_oe || sda_oe) line_act++;
      @(negedge clk);
      n++;
    end
    checkOutput("delay_busy_cycles", 32'(busy_cycles), (units == 16'd0) ? 32'd1 : 32'(units) * 32'd10);
    checkOutput("delay_done_pulse", 32'(done), 32'd1);
    checkOutput("delay_line_activity", 32'(line_act), 32'd0);
  endtask

  function automatic logic [31:0] randWord();
    logic [31:0] w;
    w = $urandom;
    if (w[31:24] == 8'hFF) w[31:24] = 8'h78;
    return w;
  endfunction

  initial begin
    logic [31:0] words [0:2];
    logic [31:0] w1;
    logic [31:0] w2;
    int          ni;
    int          n;
    int          bad;
    bit          found;

    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_fifo_read", 32'(fifo_read), 32'd0);
    checkOutput("rst_scl_oe", 32'(scl_oe), 32'd0);
    checkOutput("rst_sda_oe", 32'(sda_oe), 32'd0);
    checkOutput("rst_busy", 32'(busy), 32'd0);
    checkOutput("rst_done", 32'(done), 32'd0);
    checkOutput("rst_nack_err", 32'(nack_err), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    $display("[TB] single write");
    runWord("t1", 32'h7830_0882, -1);
    checkOutput("t1_pops", 32'(pop_cnt), 32'd1);

    $display("[TB] NACK on address then a normal write");
    runWord("t2a", 32'h7831_0311, 0);
    runWord("t2b", 32'h7830_0802, -1);

    $display("[TB] delays");
    runDelay(16'd3);
    runDelay(16'd0);
    runDelay(16'($urandom_range(1, 4)));

    $display("[TB] three preloaded words");
    nack_byte = -1;
    @(negedge clk);
    #1;
    for (int i = 0; i < 3; i++) begin
      words[i] = randWord();
      applyStimulus(words[i], 1'b0);
    end
    exp_done += 3;
    waitDone(exp_done);
    for (int i = 0; i < 3; i++) checkTxn("t4", words[i], -1);
    checkOutput("t4_pops", 32'(pop_cnt), 32'(wr_ptr));
    checkOutput("t4_bus_free_ge16", 32'(min_gap >= 16), 32'd1);

    $display("[TB] random words");
    for (int i = 0; i < 6; i++) begin
      ni = $urandom_range(0, 5);
      runWord("rnd", randWord(), (ni < 4) ? ni : -1);
    end

    $display("[TB] reset mid-byte");
    nack_byte = -1;
    w1 = randWord();
    w2 = randWord();
    applyStimulus(w1, 1'b1);
    applyStimulus(w2, 1'b0);
    found = 1'b0;
    n = 0;
    while (!found && n < 3000) begin
      @(negedge clk);
      #1;
      n++;
      if (mon_active && mon_byte_idx == 1 && mon_bit_n == 5) found = 1'b1;
    end
    checkOutput("t5_reached_bit5", 32'(found), 32'd1);
    #1 rst = 1'b1;
    #1;
    checkOutput("t5_scl_released", 32'(scl_oe), 32'd0);
    checkOutput("t5_sda_released", 32'(sda_oe), 32'd0);
    checkOutput("t5_busy_cleared", 32'(busy), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    exp_nack = 1'b0;
    exp_done++;
    waitDone(exp_done);
    checkTxn("t5", w2, -1);
    checkOutput("t5_nack_err", 32'(nack_err), 32'd0);

    $display("[TB] idle with empty FIFO");
    bad = 0;
    repeat (1000) begin
      @(negedge clk);
      if (fifo_read || scl_oe || sda_oe || busy) bad++;
    end
    checkOutput("t6_idle_activity", 32'(bad), 32'd0);

    checkOutput("total_pops", 32'(pop_cnt), 32'(wr_ptr));
    checkOutput("fifo_drained", 32'(rd_ptr), 32'(wr_ptr));
    checkOutput("total_done", 32'(done_cnt), 32'(exp_done));
    checkOutput("pop_protocol", 32'(pop_vio), 32'd0);
    checkOutput("done_single_cycle", 32'(done_vio), 32'd0);
    checkOutput("no_stray_txn", 32'(obs_wr), 32'(obs_rd));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
